// File: rtl/dadda_result_writer.sv
// rtl/dadda_result_writer.sv - writes each accepted product into result RAM port B; optional XOR checksum under RESULT_CHECKSUM_EN
module dadda_result_writer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              start_stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] product,
    output logic              web,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] dinb,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              web_q, web_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;
    logic [DATA_W-1:0] dinb_q, dinb_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // A product is taken only while already running; the IDLE->RUN edge takes nothing
    logic accept;
    logic last_write;
    assign accept     = (state_q == S_RUN) && start_stop && in_valid;
    assign last_write = (count_q == LAST_IDX);

    // State register
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: dropping start_stop wins over everything else
    always_comb begin
        state_d = state_q;
        if (!start_stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   if (accept && last_write) state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Write-port next values: clear when idle, load on accept, otherwise hold with web low
    always_comb begin
        web_d   = 1'b0;
        addrb_d = addrb_q;
        dinb_d  = dinb_q;
        count_d = count_q;
        if (!start_stop) begin
            addrb_d = '0;
            dinb_d  = '0;
            count_d = '0;
        end else if (accept) begin
            web_d   = 1'b1;
            addrb_d = count_q[ADDR_W-1:0];
            dinb_d  = product;
            count_d = count_q + CNT_W'(1);
        end
    end

    // Write-port registers; the pointer is the count itself so it never wraps in a run
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            web_q   <= 1'b0;
            addrb_q <= '0;
            dinb_q  <= '0;
            count_q <= '0;
        end else begin
            web_q   <= web_d;
            addrb_q <= addrb_d;
            dinb_q  <= dinb_d;
            count_q <= count_d;
        end
    end

`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] cksum_q, cksum_d;

    // Checksum next value follows dinb: folded on accept, cleared when idle
    always_comb begin
        cksum_d = cksum_q;
        if (!start_stop) begin
            cksum_d = '0;
        end else if (accept) begin
            cksum_d = cksum_q ^ product;
        end
    end

    // Checksum register
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign checksum = cksum_q;
`else
    assign checksum = '0;
`endif

    // Outputs: done is decoded from state so it rises with the final web pulse
    always_comb begin
        web   = web_q;
        enb   = web_q;
        addrb = addrb_q;
        dinb  = dinb_q;
        count = count_q;
        done  = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_dadda_result_writer.sv
// tb/tb_dadda_result_writer.sv - scoreboard bench for dadda_result_writer
module tb_dadda_result_writer;

    logic        clka;
    logic        rst_n;
    logic        start_stop;
    logic        in_valid;
    logic [31:0] product;
    logic        web;
    logic        enb;
    logic [2:0]  addrb;
    logic [31:0] dinb;
    logic [3:0]  count;
    logic        done;
    logic [31:0] checksum;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    dadda_result_writer #(
        .DEPTH (8),
        .ADDR_W(3),
        .DATA_W(32)
    ) dut (
        .clka      (clka),
        .rst_n     (rst_n),
        .start_stop(start_stop),
        .in_valid  (in_valid),
        .product   (product),
        .web       (web),
        .enb       (enb),
        .addrb     (addrb),
        .dinb      (dinb),
        .count     (count),
        .done      (done),
        .checksum  (checksum)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write presented must match the next queued expectation
    always @(negedge clka) begin
        if (rst_n === 1'b1 && web === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addrb=%0d dinb=0x%08h with nothing expected", addrb, dinb);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (addrb !== e.addr || dinb !== e.data || enb !== 1'b1) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=0x%08h enb=%b expected addr=%0d data=0x%08h enb=1",
                             addrb, dinb, enb, e.addr, e.data);
                end
            end
        end
    end

    // One clock: inputs applied at negedge, returns at the following negedge
    task automatic cyc(input logic ss, input logic v, input logic [31:0] p);
        start_stop = ss;
        in_valid   = v;
        product    = p;
        @(posedge clka);
        @(negedge clka);
    endtask

    task automatic expect_write(input logic [2:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_web"},      {31'd0, web},   32'd0);
        chk({tag, "_done"},     {31'd0, done},  32'd0);
        chk({tag, "_count"},    {28'd0, count}, 32'd0);
        chk({tag, "_addrb"},    {29'd0, addrb}, 32'd0);
        chk({tag, "_dinb"},     dinb,           32'd0);
        chk({tag, "_checksum"}, checksum,       32'd0);
    endtask

    logic [31:0] exp_ck_full;
    logic [31:0] exp_ck_mix;

    initial begin
`ifdef RESULT_CHECKSUM_EN
        exp_ck_full = 32'h0000_0008;
        exp_ck_mix  = 32'hF0F0_0FF0;
`else
        exp_ck_full = 32'h0;
        exp_ck_mix  = 32'h0;
`endif
        rst_n      = 1'b0;
        start_stop = 1'b0;
        in_valid   = 1'b0;
        product    = 32'h0;
        #12;
        chk_cleared("reset");
        @(negedge clka);
        rst_n = 1'b1;

        // Partial run of three writes, then asynchronous reset mid-run
        cyc(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            expect_write(3'(i), 32'hA0 + 32'(i));
            cyc(1'b1, 1'b1, 32'hA0 + 32'(i));
        end
        cyc(1'b1, 1'b0, 32'h0);
        chk("pre_reset_count", {28'd0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("midrun_reset");
        @(negedge clka);
        rst_n = 1'b1;

        // Full run: products 1..8 written to addresses 0..7
        cyc(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            expect_write(3'(i), 32'(i + 1));
            cyc(1'b1, 1'b1, 32'(i + 1));
            if (i < 7) chk("full_done_low", {31'd0, done}, 32'd0);
        end
        chk("full_done_with_last", {31'd0, done}, 32'd1);
        chk("full_last_web", {31'd0, web}, 32'd1);
        chk("full_count", {28'd0, count}, 32'd8);
        cyc(1'b1, 1'b0, 32'h0);
        chk("full_done_hold", {31'd0, done}, 32'd1);
        chk("full_count_hold", {28'd0, count}, 32'd8);
        chk("full_checksum", checksum, exp_ck_full);

        // Gaps: two products three idle cycles apart
        cyc(1'b0, 1'b0, 32'h0);
        chk("stop_done", {31'd0, done}, 32'd0);
        chk("stop_count", {28'd0, count}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0);
        expect_write(3'd0, 32'h1234_0000);
        cyc(1'b1, 1'b1, 32'h1234_0000);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'hDEAD_BEEF);
            chk("gap_web", {31'd0, web}, 32'd0);
            chk("gap_dinb_hold", dinb, 32'h1234_0000);
        end
        expect_write(3'd1, 32'h0000_5678);
        cyc(1'b1, 1'b1, 32'h0000_5678);
        cyc(1'b1, 1'b0, 32'h0);
        chk("gap_count", {28'd0, count}, 32'd2);

        // Abort after five writes; the write presented with the drop still completes
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            expect_write(3'(i), 32'h50 + 32'(i));
            cyc(1'b1, 1'b1, 32'h50 + 32'(i));
        end
        cyc(1'b0, 1'b1, 32'h99);
        chk("abort_web", {31'd0, web}, 32'd0);
        chk("abort_count", {28'd0, count}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);

        // Restart rewrites from address 0; checksum of three mixed products
        cyc(1'b1, 1'b0, 32'h0);
        expect_write(3'd0, 32'hFFFF_0000);
        cyc(1'b1, 1'b1, 32'hFFFF_0000);
        expect_write(3'd1, 32'h0F0F_0F0F);
        cyc(1'b1, 1'b1, 32'h0F0F_0F0F);
        expect_write(3'd2, 32'h0000_00FF);
        cyc(1'b1, 1'b1, 32'h0000_00FF);
        chk("mix_checksum", checksum, exp_ck_mix);
        cyc(1'b1, 1'b0, 32'h0);
        chk("mix_checksum_hold", checksum, exp_ck_mix);

        // Overrun: valid asserted on the entry edge and for 12 cycles after
        cyc(1'b0, 1'b0, 32'h0);
        chk("idle_checksum_clear", checksum, 32'h0);
        cyc(1'b1, 1'b1, 32'hDEAD_0000);
        chk("entry_no_accept", {31'd0, web}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (i < 8) expect_write(3'(i), 32'hC0 + 32'(i));
            cyc(1'b1, 1'b1, 32'hC0 + 32'(i));
            if (i >= 7) chk("overrun_done", {31'd0, done}, 32'd1);
        end
        chk("overrun_count", {28'd0, count}, 32'd8);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
